// File: rtl/ascon_pkg.sv
// Shared constants and FSM encoding for the ASCON permutation control path.
package ascon_pkg;

    localparam int STATE_W    = 320;
    localparam int MAX_ROUNDS = 12;

    // Round counts used by the mode controller
    localparam int PA_ROUNDS  = 12;
    localparam int PB6_ROUNDS = 6;
    localparam int PB8_ROUNDS = 8;

    // Word slices of the packed 320-bit state (x0 is the most significant word)
    localparam int X0_HI = 319;
    localparam int X0_LO = 256;
    localparam int X1_HI = 255;
    localparam int X1_LO = 192;
    localparam int X2_HI = 191;
    localparam int X2_LO = 128;
    localparam int X3_HI = 127;
    localparam int X3_LO = 64;
    localparam int X4_HI = 63;
    localparam int X4_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Saturate a requested round count to the full permutation length
    function automatic logic [3:0] clamp_rounds(input logic [3:0] n, input logic [3:0] max_n);
        logic [3:0] r;
        if (n > max_n) begin
            r = max_n;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/ascon_round_sequencer.sv
// Iterative ASCON round sequencer: holds the 320-bit state, presents it with the
// round index to an external round datapath, writes the result back once per
// cycle and hands the permuted state out over a valid/ready handshake.
module ascon_round_sequencer
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = 12,
    parameter int STATE_W    = 320
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [3:0]         num_rounds,
    output logic [3:0]         round_number,
    output logic [63:0]        x0_o,
    output logic [63:0]        x1_o,
    output logic [63:0]        x2_o,
    output logic [63:0]        x3_o,
    output logic [63:0]        x4_o,
    input  logic [STATE_W-1:0] round_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    localparam logic [3:0] MAX_ROUNDS_4 = 4'(MAX_ROUNDS);

    seq_state_e         state_q;
    logic [STATE_W-1:0] state_reg_q;
    logic [3:0]         round_cnt_q;
    logic [3:0]         rounds_left_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [3:0]         n_clamp_d;

    assign n_clamp_d = clamp_rounds(num_rounds, MAX_ROUNDS_4);

    // Sequencer FSM with its state register, round counters and handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            state_reg_q   <= '0;
            round_cnt_q   <= 4'd0;
            rounds_left_q <= 4'd0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_reg_q   <= state_in;
                        // Shortened permutations run the tail of the round schedule
                        round_cnt_q   <= MAX_ROUNDS_4 - n_clamp_d;
                        rounds_left_q <= n_clamp_d;
                        in_ready_q    <= 1'b0;
                        if (n_clamp_d == 4'd0) begin
                            // Zero rounds: pass the state straight through
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q     <= ST_RUN;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    state_reg_q   <= round_result;
                    round_cnt_q   <= round_cnt_q + 4'd1;
                    rounds_left_q <= rounds_left_q - 4'd1;
                    if (rounds_left_q == 4'd1) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign round_number = round_cnt_q;
    assign state_out    = state_reg_q;
    assign x0_o         = state_reg_q[X0_HI:X0_LO];
    assign x1_o         = state_reg_q[X1_HI:X1_LO];
    assign x2_o         = state_reg_q[X2_HI:X2_LO];
    assign x3_o         = state_reg_q[X3_HI:X3_LO];
    assign x4_o         = state_reg_q[X4_HI:X4_LO];

endmodule

// File: doc/ascon_round_sequencer.md
Name: ascon_round_sequencer

Overview:
- Iterative control and state-holding stage that sits directly upstream of the constant-addition stage in the ASCON permutation.
- Latches a 320-bit state and drives the current state words and round_number into the combinational round datapath (constant addition -> substitution -> linear diffusion).
- Writes the datapath result back once per cycle for the requested number of rounds.
- Returns the permuted state over a valid/ready handshake; used for p^a (12 rounds) and p^b (6 or 8 rounds) by the mode controller.

Parameters:
- MAX_ROUNDS, 12, total rounds in the full permutation; also the round_number base for shortened permutations.
- STATE_W, 320, width of the ASCON state (5 x 64-bit words).

Ports:
- clk  in  1  system clock, all registers on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  start request carrying state_in and num_rounds
- in_ready  out  1  high only in IDLE
- state_in  in  320  initial state, x0 = bits [319:256] ... x4 = bits [63:0]
- num_rounds  in  4  rounds to apply; legal range 1..12
- round_number  out  4  round index to constant-addition stage
- x0_o, x1_o, x2_o, x3_o, x4_o  out  64 each  current state words to datapath
- round_result  in  320  datapath output for the current round, same packing as state_in
- out_valid  out  1  permuted state available
- out_ready  in  1  consumer accepts state_out
- state_out  out  320  final state, valid while out_valid
- busy  out  1  high in RUN

Behaviour:
- Reset values: FSM = IDLE, state_reg = 0, round_cnt = 0, rounds_left = 0, in_ready = 1, out_valid = 0, busy = 0, round_number = 0, state_out = 0.
- Reset mid-operation aborts immediately. In-progress state is discarded and out_valid drops asynchronously.
- States:
  - IDLE:
    - On in_valid & in_ready, latch state_in into state_reg.
    - Set round_cnt = MAX_ROUNDS - n, where n = clamped num_rounds.
    - Set rounds_left = n, then go to RUN.
    - If num_rounds = 0, latch state_in and go directly to DONE (bypass, state unchanged).
  - RUN:
    - round_number = round_cnt; x0_o..x4_o = state_reg slices.
    - Each cycle: state_reg <= round_result, round_cnt += 1, rounds_left -= 1.
    - When rounds_left = 1 at the clock edge, go to DONE after the final write.
  - DONE:
    - out_valid = 1; state_out = state_reg, held stable.
    - On out_valid & out_ready, return to IDLE the next cycle.
- Clamping: num_rounds > 12 is treated as 12. The first round_number is always MAX_ROUNDS - n, e.g. 6 for p^6 (constant 0x96) and 4 for p^8 (constant 0xB4).
- Latency: n + 1 cycles from the accept edge to out_valid high; 1 cycle for bypass.
- in_ready is low in RUN and DONE. in_valid in those states is ignored, with no queuing.
- round_cnt never exceeds MAX_ROUNDS - 1 while in RUN. It is 4 bits wide, with no wrap in legal operation.
- x0_o..x4_o always reflect state_reg in every state, so the datapath output is don't-care outside RUN.
- out_ready asserted outside DONE has no effect.
- in_valid asserted together with the out handshake in DONE is not accepted that cycle. It can be accepted in IDLE the next cycle.

Decomposition:
- Shared package ascon_pkg:
  - STATE_W
  - MAX_ROUNDS
  - round-count constants PA_ROUNDS = 12, PB6_ROUNDS = 6, PB8_ROUNDS = 8
  - word slice index localparams for x0..x4
  - FSM state encoding IDLE/RUN/DONE
- No sub-module inside this block. The round datapath (constant addition, substitution, linear diffusion) stays external and is wired by the permutation top, ascon_permutation_top, which instantiates this sequencer with the datapath.

Test Plan:
- Reset during RUN: assert rst at round 5 of a 12-round job -> out_valid = 0, in_ready = 1, state_out = 0 immediately; the next job runs normally.
- Full p^12: state_in = 0, num_rounds = 12, out_ready = 1, real datapath attached -> round_number steps 0..11 on consecutive cycles, out_valid after 13 cycles, state_out matches the reference-model ASCON p^12(0).
- Shortened p^6 / p^8: num_rounds = 6 -> first round_number = 6 (x2 low byte XORed with 0x96), last = 11; num_rounds = 8 -> first = 4 (0xB4). Results match the model.
- Backpressure: out_ready held low 10 cycles after DONE -> state_out stable, in_valid ignored with in_ready = 0; when out_ready rises, return to IDLE the next cycle.
- Edge counts: num_rounds = 0 -> out_valid after 1 cycle, state_out = state_in. num_rounds = 15 -> behaves exactly as 12.
- Back-to-back: in_valid held high across two jobs with out_ready = 1 -> second job accepted in the cycle after the first handshake; no lost or duplicated rounds.
